exec_mem_stage: RTL and testbench
=================================

Name: exec_mem_stage

Overview:
- Execute/memory slice of the 16-bit single-cycle CPU datapath, with three functions:
  - ALU-control decoder: ALUOp, funct and opcode in; 4-bit ALU control word out.
  - 16-bit ALU.
  - Synchronous-write data memory addressed by the ALU result.
- Sits between register-file read and write-back; result, zero and mem_rdata feed the write-back mux and the branch logic.

Parameters:
- DMEM_WORDS, 128, number of 16-bit data-memory words (power of 2).
- DATA_W, 16, datapath width; fixed at 16, present for readability only.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; clears data memory.
- ALUOp  in  2  from control unit.
- funct  in  2  instruction[1:0].
- opcode  in  4  instruction[15:12].
- op_a  in  16  readData1.
- op_b  in  16  ALUSrc mux output (register or sign-extended immediate).
- store_data  in  16  readData2.
- MemWrite  in  1  store enable.
- MemRead  in  1  load enable.
- alu_ctrl  out  4  decoded control: [3] = Binvert, [2:0] = operation.
- result  out  16  ALU result; also the memory address.
- zero  out  1  asserted when result == 0.
- overflow  out  1  signed overflow.
- carryout  out  1  carry out of bit 15.
- mem_rdata  out  16  load data.

Behaviour:
- ALU decode and ALU are fully combinational, zero latency.
- ALUOp decode:
  - 00 → ADD (0010); used by lw/sw.
  - 01 → SUB (1010); used by beq.
  - 10 → R-type, decoded from funct: 00 ADD (0010), 01 SUB (1010), 10 AND (0000), 11 OR (0001).
  - 11 → I-type, decoded from opcode: 0001 ADDI → 0010, 0010 ANDI → 0000, 0011 ORI → 0001, 0100 SLTI → 1011; any other opcode → 0010.
- ALU operation field [2:0]:
  - 000 AND, 001 OR, 010 ADD/SUB, 011 SLT, 100 XOR, 101 NOR.
  - 110 and 111 → result 0.
- Adder:
  - sum = op_a + (Binvert ? ~op_b : op_b) + Binvert, computed 17 bits wide.
  - carryout = bit 16 of sum for ops 010 and 011; otherwise 0. For SUB, carryout = 1 means no borrow.
  - overflow = (sign(a) == sign(b')) && (sign(sum) != sign(a)), where b' is the possibly inverted operand. Valid for op 010 only; 0 for all other ops.
- SLT: result = {15'b0, sum[15] XOR overflow_raw}, i.e. a signed compare.
- Binvert is ignored for logic ops.
- zero = (result == 16'h0000) for every op.
- Data memory:
  - DMEM_WORDS × 16, byte-addressed by halfword.
  - Index = result[log2(DMEM_WORDS):1]; result[0] is ignored.
  - Higher address bits are ignored, so addresses wrap.
- Write:
  - On rising Clock with MemWrite=1 and Reset=0: mem[index] ← store_data.
  - A new value becomes visible on mem_rdata only after the edge, never during the same cycle.
- Read:
  - Combinational.
  - mem_rdata = MemRead ? mem[index] : 16'h0000.
  - MemRead and MemWrite both set: the read returns the old word before the edge and the new word after it.
- Reset:
  - Asynchronous assertion clears every memory word to 0; held while Reset=1.
  - Writes are ignored during reset.
  - Combinational outputs are unaffected by reset except mem_rdata, which reads 0 from the cleared memory.
  - Reset asserted mid-operation discards any pending write on that edge.

Optional Feature:
- Macro: EXEC_ALU_SLT_EN.
- Defined: ALU op 011 performs signed SLT, and ALUOp=11 with opcode 0100 decodes to 1011.
- Undefined: op 011 yields result 0 with carryout=0 and overflow=0, and opcode 0100 decodes to ADD (0010).

Decomposition:
- Package exec_pkg holds the shared constants:
  - ALUOp codes (ALUOP_MEM, ALUOP_BEQ, ALUOP_RTYPE, ALUOP_ITYPE).
  - ALU operation codes.
  - funct codes.
  - I-type opcodes.
  - DATA_W.
- One sub-module, exec_dmem: the memory array with async-reset clear, synchronous write and combinational gated read.
- Decoder and ALU stay inline in exec_mem_stage.

Test Plan:
- ADD overflow: ALUOp=10, funct=00, a=16'h7FFF, b=16'h0001 → alu_ctrl=0010, result=16'h8000, overflow=1, carryout=0, zero=0.
- beq compare: ALUOp=01, a=b=16'h1234 → alu_ctrl=1010, result=0, zero=1, carryout=1. Then with b=16'h1235 → result=16'hFFFF, carryout=0.
- Logic ops:
  - ALUOp=10, funct=10, a=16'hF0F0, b=16'h0FF0 → result=16'h00F0.
  - Same operands with funct=11 → 16'hFFF0.
  - ALUOp=11, opcode=0011 → alu_ctrl=0001.
- SLT with EXEC_ALU_SLT_EN defined: ALUOp=11, opcode=0100, a=16'hFFFE (−2), b=16'h0003 → result=1. Then a=3, b=−2 → result=0. With the macro undefined, the first case gives alu_ctrl=0010 and result=16'h0001.
- Store/load:
  - ALUOp=00, a=16'h000A, b=16'h0004, MemWrite=1, store_data=16'hBEEF, one Clock edge.
  - Then MemWrite=0, MemRead=1 → mem_rdata=16'hBEEF.
  - MemRead=0 → mem_rdata=0.
  - Address 16'h000F reads the same word (bit 0 ignored).
- Reset and wrap:
  - Write 16'hA5A5 to address 2; pulse Reset between clock edges → MemRead at address 2 returns 0.
  - Assert Reset together with MemWrite across an edge → word stays 0.
  - Address 2 + 2*DMEM_WORDS aliases address 2.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared ALU/decode constants for the execute/memory stage
package exec_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;

    localparam logic [1:0] FUNCT_ADD = 2'b00;
    localparam logic [1:0] FUNCT_SUB = 2'b01;
    localparam logic [1:0] FUNCT_AND = 2'b10;
    localparam logic [1:0] FUNCT_OR  = 2'b11;

    localparam logic [3:0] OPC_ADDI = 4'b0001;
    localparam logic [3:0] OPC_ANDI = 4'b0010;
    localparam logic [3:0] OPC_ORI  = 4'b0011;
    localparam logic [3:0] OPC_SLTI = 4'b0100;

    // Full control words: bit 3 is Binvert, bits 2:0 the ALU operation.
    localparam logic [3:0] CTRL_ADD = {1'b0, OP_ADD};
    localparam logic [3:0] CTRL_SUB = {1'b1, OP_ADD};
    localparam logic [3:0] CTRL_AND = {1'b0, OP_AND};
    localparam logic [3:0] CTRL_OR  = {1'b0, OP_OR};
    localparam logic [3:0] CTRL_SLT = {1'b1, OP_SLT};

endpackage

// File: rtl/exec_dmem.sv
// rtl/exec_dmem.sv - data memory: async-reset clear, synchronous write, gated combinational read
module exec_dmem
    import exec_pkg::*;
#(
    parameter int WORDS = 128
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int AW = $clog2(WORDS);

    logic [DATA_W-1:0] mem [WORDS];
    logic [AW-1:0]     idx;
    logic              unused_addr_bits;

    // Halfword addressing: bit 0 and everything above the index wrap away.
    assign idx              = addr[AW:1];
    assign unused_addr_bits = ^{addr[DATA_W-1:AW+1], addr[0]};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = re ? mem[idx] : '0;

endmodule

// File: rtl/exec_mem_stage.sv
// rtl/exec_mem_stage.sv - ALU control decode, 16-bit ALU and data memory; EXEC_ALU_SLT_EN enables SLT
module exec_mem_stage #(
    parameter int DMEM_WORDS = 128,
    parameter int DATA_W     = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [1:0]        ALUOp,
    input  logic [1:0]        funct,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] store_data,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              carryout,
    output logic [DATA_W-1:0] mem_rdata
);

    import exec_pkg::*;

    always_comb begin
        alu_ctrl = CTRL_ADD;
        case (ALUOp)
            ALUOP_MEM: alu_ctrl = CTRL_ADD;
            ALUOP_BEQ: alu_ctrl = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = CTRL_ADD;
                    FUNCT_SUB: alu_ctrl = CTRL_SUB;
                    FUNCT_AND: alu_ctrl = CTRL_AND;
                    default:   alu_ctrl = CTRL_OR;
                endcase
            end
            default: begin
                case (opcode)
                    OPC_ADDI: alu_ctrl = CTRL_ADD;
                    OPC_ANDI: alu_ctrl = CTRL_AND;
                    OPC_ORI:  alu_ctrl = CTRL_OR;
`ifdef EXEC_ALU_SLT_EN
                    OPC_SLTI: alu_ctrl = CTRL_SLT;
`endif
                    default:  alu_ctrl = CTRL_ADD;
                endcase
            end
        endcase
    end

    logic              binvert;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              ov_raw;

    assign binvert = alu_ctrl[3];
    assign alu_op  = alu_ctrl[2:0];
    assign b_eff   = binvert ? ~op_b : op_b;
    assign sum     = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, binvert};
    assign ov_raw  = (op_a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);

    // Binvert only steers the adder; logic ops see the raw operands.
    always_comb begin
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (alu_op)
            OP_AND: result = op_a & op_b;
            OP_OR:  result = op_a | op_b;
            OP_ADD: begin
                result   = sum[DATA_W-1:0];
                carryout = sum[DATA_W];
                overflow = ov_raw;
            end
`ifdef EXEC_ALU_SLT_EN
            OP_SLT: begin
                result   = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ ov_raw};
                carryout = sum[DATA_W];
            end
`endif
            OP_XOR: result = op_a ^ op_b;
            OP_NOR: result = ~(op_a | op_b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    exec_dmem #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .Clock (Clock),
        .Reset (Reset),
        .we    (MemWrite),
        .re    (MemRead),
        .addr  (result),
        .wdata (store_data),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_exec_mem_stage.sv
// tb/tb_exec_mem_stage.sv - randomized and directed checks against a behavioural model
module tb_exec_mem_stage;

    localparam int DMEM_WORDS = 128;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  ALUOp;
    logic [1:0]  funct;
    logic [3:0]  opcode;
    logic [15:0] op_a, op_b, store_data;
    logic        MemWrite, MemRead;
    logic [3:0]  alu_ctrl;
    logic [15:0] result, mem_rdata;
    logic        zero, overflow, carryout;

    exec_mem_stage #(.DMEM_WORDS(DMEM_WORDS), .DATA_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .ALUOp(ALUOp), .funct(funct), .opcode(opcode),
        .op_a(op_a), .op_b(op_b), .store_data(store_data), .MemWrite(MemWrite),
        .MemRead(MemRead), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
        .overflow(overflow), .carryout(carryout), .mem_rdata(mem_rdata)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_SLT} mop_t;

    logic [15:0] mem_model [DMEM_WORDS];
    logic [3:0]  e_ctrl;
    logic [15:0] e_res;
    logic        e_ov, e_co;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mop_t ref_op(input logic [1:0] aop, input logic [1:0] f, input logic [3:0] opc);
        if (aop == 2'b00) return M_ADD;
        if (aop == 2'b01) return M_SUB;
        if (aop == 2'b10) begin
            case (f)
                2'b00: return M_ADD;
                2'b01: return M_SUB;
                2'b10: return M_AND;
                default: return M_OR;
            endcase
        end
        case (opc)
            4'b0010: return M_AND;
            4'b0011: return M_OR;
`ifdef EXEC_ALU_SLT_EN
            4'b0100: return M_SLT;
`endif
            default: return M_ADD;
        endcase
    endfunction

    function automatic int ref_idx(input logic [15:0] addr);
        return (int'(addr) / 2) % DMEM_WORDS;
    endfunction

    task automatic model();
        int unsigned ua, ub, u;
        int sa, sb, s;
        mop_t m;
        ua = op_a; ub = op_b;
        sa = $signed(op_a); sb = $signed(op_b);
        m = ref_op(ALUOp, funct, opcode);
        e_ov = 1'b0; e_co = 1'b0;
        case (m)
            M_ADD: begin
                e_ctrl = 4'b0010; u = ua + ub; e_res = u[15:0];
                e_co = (u > 65535); s = sa + sb; e_ov = (s > 32767) || (s < -32768);
            end
            M_SUB: begin
                e_ctrl = 4'b1010; u = ua - ub; e_res = u[15:0];
                e_co = (ua >= ub); s = sa - sb; e_ov = (s > 32767) || (s < -32768);
            end
            M_AND: begin e_ctrl = 4'b0000; e_res = op_a & op_b; end
            M_OR:  begin e_ctrl = 4'b0001; e_res = op_a | op_b; end
            default: begin
                e_ctrl = 4'b1011; e_res = (sa < sb) ? 16'd1 : 16'd0; e_co = (ua >= ub);
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        model();
        chk({tag, ".ctrl"}, alu_ctrl, e_ctrl);
        chk({tag, ".res"},  result,   e_res);
        chk({tag, ".zero"}, zero,     (e_res == 16'h0));
        chk({tag, ".ov"},   overflow, e_ov);
        chk({tag, ".co"},   carryout, e_co);
        chk({tag, ".rd"},   mem_rdata, (MemRead && !Reset) ? mem_model[ref_idx(e_res)] : 16'h0);
    endtask

    task automatic drive(input logic [1:0] aop, input logic [1:0] f, input logic [3:0] opc,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic we, input logic re, input logic [15:0] wd);
        ALUOp = aop; funct = f; opcode = opc; op_a = a; op_b = b;
        MemWrite = we; MemRead = re; store_data = wd;
        #1;
    endtask

    // Advances one rising edge and mirrors the write into the model.
    task automatic edge_step();
        model();
        @(posedge Clock);
        if (MemWrite && !Reset) mem_model[ref_idx(e_res)] = store_data;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DMEM_WORDS; i++) mem_model[i] = 16'h0;
    endtask

    initial begin
        clear_model();
        Reset = 1'b1;
        drive(2'b00, 2'b00, 4'b0000, 16'h0003, 16'h0004, 1'b1, 1'b1, 16'h1111);
        check_all("rst");
        chk("rst.res_const", result, 16'h0007);
        chk("rst.rd_const", mem_rdata, 16'h0000);
        @(posedge Clock); #1;
        chk("rst.write_ignored", mem_rdata, 16'h0000);
        @(negedge Clock);
        Reset = 1'b0;
        drive(2'b00, 2'b00, 4'b0000, 16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0);
        chk("rst.after", mem_rdata, 16'h0000);

        @(negedge Clock);
        drive(2'b10, 2'b00, 4'b0000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0);
        check_all("addov");
        chk("addov.ctrl_c", alu_ctrl, 4'b0010);
        chk("addov.res_c", result, 16'h8000);
        chk("addov.ov_c", overflow, 1'b1);
        chk("addov.co_c", carryout, 1'b0);

        drive(2'b01, 2'b00, 4'b0000, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0);
        check_all("beq_eq");
        chk("beq_eq.ctrl_c", alu_ctrl, 4'b1010);
        chk("beq_eq.zero_c", zero, 1'b1);
        chk("beq_eq.co_c", carryout, 1'b1);
        drive(2'b01, 2'b00, 4'b0000, 16'h1234, 16'h1235, 1'b0, 1'b0, 16'h0);
        check_all("beq_ne");
        chk("beq_ne.res_c", result, 16'hFFFF);
        chk("beq_ne.co_c", carryout, 1'b0);

        drive(2'b10, 2'b10, 4'b0000, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 16'h0);
        chk("and.res_c", result, 16'h00F0);
        drive(2'b10, 2'b11, 4'b0000, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 16'h0);
        chk("or.res_c", result, 16'hFFF0);
        drive(2'b11, 2'b00, 4'b0011, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 16'h0);
        chk("ori.ctrl_c", alu_ctrl, 4'b0001);

        drive(2'b11, 2'b00, 4'b0100, 16'hFFFE, 16'h0003, 1'b0, 1'b0, 16'h0);
        check_all("slt1");
`ifdef EXEC_ALU_SLT_EN
        chk("slt1.ctrl_c", alu_ctrl, 4'b1011);
        chk("slt1.res_c", result, 16'h0001);
        drive(2'b11, 2'b00, 4'b0100, 16'h0003, 16'hFFFE, 1'b0, 1'b0, 16'h0);
        check_all("slt2");
        chk("slt2.res_c", result, 16'h0000);
`else
        chk("slt1.ctrl_c", alu_ctrl, 4'b0010);
        chk("slt1.res_c", result, 16'h0001);
`endif

        drive(2'b00, 2'b00, 4'b0000, 16'h000A, 16'h0004, 1'b1, 1'b0, 16'hBEEF);
        edge_step();
        @(negedge Clock);
        drive(2'b00, 2'b00, 4'b0000, 16'h000A, 16'h0004, 1'b0, 1'b1, 16'h0);
        chk("ld.rd_c", mem_rdata, 16'hBEEF);
        drive(2'b00, 2'b00, 4'b0000, 16'h000A, 16'h0004, 1'b0, 1'b0, 16'h0);
        chk("ld.gated", mem_rdata, 16'h0000);
        drive(2'b00, 2'b00, 4'b0000, 16'h000F, 16'h0000, 1'b0, 1'b1, 16'h0);
        chk("ld.bit0", mem_rdata, 16'hBEEF);

        drive(2'b00, 2'b00, 4'b0000, 16'h000E, 16'h0000, 1'b1, 1'b1, 16'h4321);
        chk("rw.old", mem_rdata, 16'hBEEF);
        edge_step();
        chk("rw.new", mem_rdata, 16'h4321);

        @(negedge Clock);
        drive(2'b00, 2'b00, 4'b0000, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'hA5A5);
        edge_step();
        @(negedge Clock);
        drive(2'b00, 2'b00, 4'b0000, 16'h0002, 16'h0000, 1'b0, 1'b1, 16'h0);
        chk("rp.pre", mem_rdata, 16'hA5A5);
        Reset = 1'b1; #2; Reset = 1'b0; clear_model(); #1;
        chk("rp.cleared", mem_rdata, 16'h0000);
        drive(2'b00, 2'b00, 4'b0000, 16'h000E, 16'h0000, 1'b0, 1'b1, 16'h0);
        chk("rp.other", mem_rdata, 16'h0000);

        @(negedge Clock);
        Reset = 1'b1;
        drive(2'b00, 2'b00, 4'b0000, 16'h0002, 16'h0000, 1'b1, 1'b1, 16'hA5A5);
        edge_step();
        @(negedge Clock);
        Reset = 1'b0;
        drive(2'b00, 2'b00, 4'b0000, 16'h0002, 16'h0000, 1'b0, 1'b1, 16'h0);
        chk("rw_rst.word", mem_rdata, 16'h0000);

        @(negedge Clock);
        drive(2'b00, 2'b00, 4'b0000, 16'h0002 + 16'(2 * DMEM_WORDS), 16'h0000, 1'b1, 1'b0, 16'h5A5A);
        edge_step();
        @(negedge Clock);
        drive(2'b00, 2'b00, 4'b0000, 16'h0002, 16'h0000, 1'b0, 1'b1, 16'h0);
        chk("wrap.alias", mem_rdata, 16'h5A5A);

        for (int it = 0; it < 200; it++) begin
            logic [15:0] a, b;
            logic [1:0]  aop;
            @(negedge Clock);
            aop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                aop = 2'b00;
                a = 16'($urandom_range(0, 127));
                b = 16'($urandom_range(0, 127));
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
                if ($urandom_range(0, 7) == 0) b = a;
            end
            drive(aop, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), a, b,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            check_all("rnd.pre");
            edge_step();
            chk("rnd.post", mem_rdata, MemRead ? mem_model[ref_idx(e_res)] : 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
